ldst_seq: RTL and testbench

Multi-cycle sequencer for the load/store datapath. It accepts one load or store request at a time and steps it through four phases: register-file read, address generation (rs1 + offset), data-memory access with a wait-state handshake, and load writeback. It sits between instruction issue and the shared register file and data memory. It owns all enables to both resources, so only one memory transaction is ever in flight.

---
 rtl/ldst_pkg.sv | 19 +
 rtl/ldst_seq_if.sv | 58 +++++
 rtl/ldst_agen.sv | 19 +
 rtl/ldst_seq.sv | 135 +++++++++++++
 tb/tb_ldst_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ldst_pkg.sv
// Shared types and constants for the load/store sequencer:
// FSM state encoding, err_code values and the default data width.
package ldst_pkg;

    localparam int XLEN_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        RREG,
        ADDR,
        MEM,
        WB
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/ldst_seq_if.sv
// Request, register-file, data-memory and status bundle of ldst_seq.
// slave = sequencer side, master = issue/register-file/memory side.
interface ldst_seq_if
    import ldst_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) ();
    logic            req_valid;
    logic            req_ready;
    logic            req_is_store;
    logic [4:0]      req_rs1;
    logic [4:0]      req_rs2;
    logic [4:0]      req_rd;
    logic [XLEN-1:0] req_offset;

    logic [4:0]      rf_raddr1;
    logic [4:0]      rf_raddr2;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    logic            done;
    logic            err;
    logic [1:0]      err_code;

    modport slave (
        input  req_valid, req_is_store, req_rs1, req_rs2,
        input  req_rd, req_offset,
        output req_ready,
        output rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2,
        output rf_we, rf_waddr, rf_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output done, err, err_code
    );

    modport master (
        output req_valid, req_is_store, req_rs1, req_rs2,
        output req_rd, req_offset,
        input  req_ready,
        input  rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2,
        input  rf_we, rf_waddr, rf_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  done, err, err_code
    );
endinterface

// File: rtl/ldst_agen.sv
// Address generator: addr = base + offset (wraps at XLEN),
// misaligned when any of the low ALIGN_BITS bits of addr are set.
module ldst_agen
    import ldst_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int ALIGN_BITS = 3
) (
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] offset,
    output logic [XLEN-1:0] addr,
    output logic            misaligned
);
    localparam logic [XLEN-1:0] MASK =
        (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    assign addr       = base + offset;
    assign misaligned = |(addr & MASK);
endmodule

// File: rtl/ldst_seq.sv
// Load/store sequencer: RREG -> ADDR -> MEM (wait/timeout) -> WB.
// Ports: clk, reset (sync, active high), bus (ldst_seq_if.slave).
module ldst_seq
    import ldst_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int ALIGN_BITS = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       reset,
    ldst_seq_if.slave  bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

    state_t          state;
    logic            is_store_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] offset_q;
    logic [XLEN-1:0] base_q;
    logic [XLEN-1:0] sdata_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] sum;
    logic            misal;

    ldst_agen #(
        .XLEN       (XLEN),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_agen (
        .base       (base_q),
        .offset     (offset_q),
        .addr       (sum),
        .misaligned (misal)
    );

    assign bus.req_ready = (state == IDLE) && !reset;

    // rf_raddr1/2 double as the captured rs1/rs2; mem_addr holds the
    // generated address and rf_wdata holds the loaded data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            is_store_q    <= 1'b0;
            rd_q          <= '0;
            offset_q      <= '0;
            base_q        <= '0;
            sdata_q       <= '0;
            cnt           <= '0;
            bus.rf_raddr1 <= '0;
            bus.rf_raddr2 <= '0;
            bus.rf_we     <= 1'b0;
            bus.rf_waddr  <= '0;
            bus.rf_wdata  <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.err_code  <= ERR_NONE;
        end else begin
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.err_code <= ERR_NONE;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        is_store_q    <= bus.req_is_store;
                        rd_q          <= bus.req_rd;
                        offset_q      <= bus.req_offset;
                        bus.rf_raddr1 <= bus.req_rs1;
                        bus.rf_raddr2 <= bus.req_rs2;
                        state         <= RREG;
                    end
                end
                RREG: begin
                    base_q  <= bus.rf_rdata1;
                    sdata_q <= bus.rf_rdata2;
                    state   <= ADDR;
                end
                ADDR: begin
                    if (misal) begin
                        bus.done     <= 1'b1;
                        bus.err      <= 1'b1;
                        bus.err_code <= ERR_MISALIGN;
                        state        <= IDLE;
                    end else begin
                        cnt           <= '0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= is_store_q;
                        bus.mem_addr  <= sum;
                        bus.mem_wdata <= is_store_q ? sdata_q : '0;
                        state         <= MEM;
                    end
                end
                MEM: begin
                    if (bus.mem_ack || cnt == CMAX) begin
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                    end
                    // An ack in the last allowed cycle still wins.
                    if (bus.mem_ack) begin
                        if (is_store_q) begin
                            bus.done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            bus.rf_we    <= (rd_q != 5'd0);
                            bus.rf_waddr <= rd_q;
                            bus.rf_wdata <= bus.mem_rdata;
                            state        <= WB;
                        end
                    end else if (cnt == CMAX) begin
                        bus.done     <= 1'b1;
                        bus.err      <= 1'b1;
                        bus.err_code <= ERR_TIMEOUT;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WB: begin
                    bus.rf_we    <= 1'b0;
                    bus.rf_waddr <= '0;
                    bus.rf_wdata <= '0;
                    bus.done     <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ldst_seq.sv
// Scoreboard bench for ldst_seq: directed and random load/store
// requests against a reference model of registers and memory.
module tb_ldst_seq;
    import ldst_pkg::*;

    localparam int XLEN = 64;
    localparam int TMO  = 8;

    typedef struct {
        logic        st;
        int          kind;   // 0 ok, 1 misaligned, 2 timeout
        logic [63:0] addr;
        logic [63:0] data;
        logic [4:0]  rd;
        int          lat;
        int          mcyc;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ldst_seq_if #(.XLEN(XLEN)) bus ();

    ldst_seq #(
        .XLEN       (XLEN),
        .ALIGN_BITS (3),
        .TIMEOUT    (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    // Environment register file (written by the DUT or by pokes).
    logic [63:0] rf [32];
    logic        poke_en = 1'b0;
    logic [4:0]  poke_idx = 5'd0;
    logic [63:0] poke_val = 64'd0;
    always @(posedge clk) begin
        if (poke_en) rf[poke_idx] <= poke_val;
        else if (bus.rf_we && bus.rf_waddr != 5'd0)
            rf[bus.rf_waddr] <= bus.rf_wdata;
    end
    assign bus.rf_rdata1 = rf[bus.rf_raddr1];
    assign bus.rf_rdata2 = rf[bus.rf_raddr2];

    // Reference model state.
    logic [63:0] rfm [32];
    logic [63:0] mm [logic [63:0]];
    exp_t        exp_q [$];
    int          wait_q [$];

    function automatic logic [63:0] mem_init(input logic [63:0] a);
        return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
    endfunction

    function automatic logic [63:0] model_rd(input logic [63:0] a);
        return mm.exists(a) ? mm[a] : mem_init(a);
    endfunction

    // Memory responder: acks after the planned number of wait cycles.
    logic [63:0] emem [logic [63:0]];
    logic        late_ack = 1'b0;
    logic        rsp_prev = 1'b0;
    int          rsp_w = 0;
    int          rsp_k = 0;
    always @(negedge clk) begin
        if (bus.mem_req && !reset) begin
            if (!rsp_prev) begin
                rsp_w = (wait_q.size() != 0) ? wait_q.pop_front() : 1000;
                rsp_k = 0;
            end
            if (rsp_k == rsp_w) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = emem.exists(bus.mem_addr) ?
                    emem[bus.mem_addr] : mem_init(bus.mem_addr);
                if (bus.mem_we) emem[bus.mem_addr] = bus.mem_wdata;
            end else begin
                bus.mem_ack = 1'b0;
                bus.mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
            end
            rsp_k++;
        end else begin
            bus.mem_ack = late_ack;
            bus.mem_rdata = 64'h0000_0000_0000_0BAD;
        end
        rsp_prev = bus.mem_req && !reset;
    end

    // Monitor: compares DUT activity against the queue front.
    int   m_mc = 0;
    int   m_wb = 0;
    int   m_wbcyc = 0;
    logic m_prev = 1'b0;
    exp_t m_e;
    always @(negedge clk) begin
        #1;
        if (reset) begin
            m_mc = 0;
            m_wb = 0;
            m_prev = 1'b0;
        end else begin
            if (bus.mem_req) begin
                if (exp_q.size() == 0 || exp_q[0].kind == 1) begin
                    chk("mem_req_unexpected", 64'd1, 64'd0);
                end else if (!m_prev) begin
                    chk("mem_addr", bus.mem_addr, exp_q[0].addr);
                    chk("mem_we", 64'(bus.mem_we), 64'(exp_q[0].st));
                    chk("mem_wdata", bus.mem_wdata,
                        exp_q[0].st ? exp_q[0].data : 64'd0);
                end else begin
                    chk("mem_addr_hold", bus.mem_addr, exp_q[0].addr);
                end
                m_mc++;
            end
            if (bus.rf_we) begin
                if (exp_q.size() == 0 || exp_q[0].st ||
                    exp_q[0].kind != 0 || exp_q[0].rd == 5'd0) begin
                    chk("rf_we_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("rf_waddr", 64'(bus.rf_waddr), 64'(exp_q[0].rd));
                    chk("rf_wdata", bus.rf_wdata, exp_q[0].data);
                end
                m_wb++;
                m_wbcyc = cyc;
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("err", 64'(bus.err), 64'(m_e.kind != 0));
                    chk("err_code", 64'(bus.err_code),
                        m_e.kind == 1 ? 64'(ERR_MISALIGN) :
                        m_e.kind == 2 ? 64'(ERR_TIMEOUT) :
                        64'(ERR_NONE));
                    chk("latency", 64'(cyc - m_e.acc), 64'(m_e.lat));
                    chk("mem_cycles", 64'(m_mc), 64'(m_e.mcyc));
                    if (!m_e.st && m_e.kind == 0 && m_e.rd != 5'd0) begin
                        chk("wb_count", 64'(m_wb), 64'd1);
                        chk("wb_before_done", 64'(m_wbcyc), 64'(cyc - 1));
                    end else begin
                        chk("wb_count", 64'(m_wb), 64'd0);
                    end
                end
                m_mc = 0;
                m_wb = 0;
            end else begin
                chk("err_without_done",
                    64'({bus.err, bus.err_code}), 64'd0);
            end
            m_prev = bus.mem_req;
        end
    end

    task automatic set_reg(input logic [4:0] idx, input logic [63:0] v);
        poke_en = 1'b1;
        poke_idx = idx;
        poke_val = v;
        rfm[idx] = v;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic issue(input logic st, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [63:0] off, input int w,
                         input logic b2b = 1'b0);
        exp_t        e;
        logic [63:0] a;
        int          n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk("ready_timeout", 64'd0, 64'd1);
                return;
            end
        end
        if (b2b) chk("b2b_accept_on_done", 64'(bus.done), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_is_store = st;
        bus.req_rs1 = rs1;
        bus.req_rs2 = rs2;
        bus.req_rd = rd;
        bus.req_offset = off;
        a = rfm[rs1] + off;
        e.st = st;
        e.addr = a;
        e.rd = rd;
        e.acc = cyc;
        e.data = st ? rfm[rs2] : model_rd(a);
        if ((a % 8) != 0) e.kind = 1;
        else if (w >= TMO) e.kind = 2;
        else e.kind = 0;
        case (e.kind)
            1: begin e.lat = 3; e.mcyc = 0; end
            2: begin e.lat = 3 + TMO; e.mcyc = TMO; end
            default: begin
                e.lat = (st ? 4 : 5) + w;
                e.mcyc = w + 1;
                if (st) mm[a] = rfm[rs2];
                else if (rd != 5'd0) rfm[rd] = e.data;
            end
        endcase
        exp_q.push_back(e);
        if (e.kind != 1) wait_q.push_back(w);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_offset = 64'h5555_AAAA_5555_AAAA;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                chk("idle_timeout", 64'(exp_q.size()), 64'd0);
                exp_q.delete();
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        st;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] off;
        int          w;

        bus.req_valid = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_rs1 = 5'd0;
        bus.req_rs2 = 5'd0;
        bus.req_rd = 5'd0;
        bus.req_offset = 64'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_raddr1", 64'(bus.rf_raddr1), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("ready_after_rst", 64'(bus.req_ready), 64'd1);

        set_reg(5'd0, 64'd0);
        for (int i = 1; i < 32; i++) begin
            if (i >= 8 && i <= 15)
                set_reg(5'(i), 64'h1000 + 64'(i) * 64'h40);
            else
                set_reg(5'(i), {$urandom, $urandom});
        end

        // Aligned store, ack in first MEM cycle.
        set_reg(5'd2, 64'h100);
        set_reg(5'd6, 64'hDEAD);
        issue(1'b1, 5'd2, 5'd6, 5'd0, 64'd8, 0);
        wait_idle();

        // Store 0x1234 at 0x200, then load it back after 3 waits.
        set_reg(5'd7, 64'h1234);
        issue(1'b1, 5'd0, 5'd7, 5'd0, 64'h200, 1);
        set_reg(5'd3, 64'h1F8);
        wait_idle();
        issue(1'b0, 5'd3, 5'd0, 5'd5, 64'd8, 3);
        wait_idle();
        chk("load_x5", rf[5], 64'h1234);

        // Wrap-around address, load into x0.
        set_reg(5'd4, 64'hFFFF_FFFF_FFFF_FFF8);
        issue(1'b0, 5'd4, 5'd0, 5'd0, 64'h10, 0);
        wait_idle();
        chk("x0_stays_zero", rf[0], 64'd0);

        // Misaligned, next request accepted in the done cycle.
        issue(1'b1, 5'd2, 5'd6, 5'd0, 64'd6, 0);
        issue(1'b1, 5'd2, 5'd6, 5'd0, 64'd16, 0, 1'b1);
        wait_idle();

        // Timeout, then a late ack that must be ignored.
        issue(1'b0, 5'd2, 5'd0, 5'd9, 64'd0, 100);
        wait_idle();
        late_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #2;
            chk("late_ack_done", 64'(bus.done), 64'd0);
            chk("late_ack_rf_we", 64'(bus.rf_we), 64'd0);
            chk("late_ack_ready", 64'(bus.req_ready), 64'd1);
        end
        late_ack = 1'b0;

        // Ack in the last allowed MEM cycle, and one cycle too late.
        issue(1'b0, 5'd2, 5'd0, 5'd10, 64'h20, TMO - 1);
        issue(1'b1, 5'd2, 5'd6, 5'd0, 64'h28, TMO);
        wait_idle();

        // Reset on the second MEM cycle of a store.
        issue(1'b1, 5'd2, 5'd6, 5'd0, 64'h3F00, 100);
        n = 0;
        while (!bus.mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reset_test_mem_req_seen", 64'(bus.mem_req), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        #2;
        chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("abort_mem_req", 64'(bus.mem_req), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_ready", 64'(bus.req_ready), 64'd1);
        issue(1'b1, 5'd2, 5'd6, 5'd0, 64'h18, 0);
        issue(1'b0, 5'd2, 5'd0, 5'd11, 64'h18, 0);
        wait_idle();
        chk("reload_x11", rf[11], 64'hDEAD);

        // Random traffic.
        repeat (40) begin
            st = 1'($urandom_range(0, 1));
            rs1 = 5'($urandom_range(8, 15));
            rs2 = 5'($urandom_range(0, 31));
            rd = ($urandom_range(0, 4) == 0) ? 5'd0 :
                 5'($urandom_range(16, 31));
            off = 64'($urandom_range(0, 31)) * 64'd8;
            if ($urandom_range(0, 3) == 0)
                off = off + 64'($urandom_range(1, 7));
            w = ($urandom_range(0, 5) == 0) ?
                int'($urandom_range(TMO - 1, TMO + 1)) :
                int'($urandom_range(0, 3));
            issue(st, rs1, rs2, rd, off, w);
        end
        wait_idle();
        for (int i = 16; i < 32; i++)
            chk("final_rf", rf[i], rfm[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
